load_use_hazard_ctrl: RTL and testbench

- Parametrised load-use hazard detection unit for the 5-stage RISC-V pipeline. It sits between the ID stage and the ID/EX register.
- Supports configurable load-to-use latency (LOAD_LAT bubbles for a dependent instruction that immediately follows a load) and a global data-memory stall input that freezes the pipe.
- Drives the existing control contract: Stall_o (hold IF/ID), PCWrite_o (PC enable), NoOp_o (zero ID/EX control).
- Adds x0 and operand-used qualification, flush suppression, and a saturating stall-cycle counter.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/load_pending_sreg.sv | 68 ++++++
 rtl/load_use_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_load_use_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared pipeline definitions for the load-use hazard logic:
//            register index width, the x0 index constant and the pending-load
//            entry type carried down the hazard shift register.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // Register index width of the RISC-V integer register file.
   localparam int REG_AW = 5;

   // x0 is hard-wired to zero: it never carries a real dependency.
   localparam logic [REG_AW-1:0] X0_IDX = '0;

   // One in-flight load that has already left ID/EX.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
   } pend_entry_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/load_pending_sreg.sv
`default_nettype none
// ============================================================================
// Module   : load_pending_sreg
// Purpose  : Depth-DEPTH shift register of loads that have left ID/EX but whose
//            data is not yet forwardable. Entry k (0-based) is the load that
//            left ID/EX k+1 cycles ago. Each entry is compared against both
//            ID-stage sources and the per-source hits are OR-reduced.
// Ports    : clk_i         rising-edge clock
//            rst_i         asynchronous active-low reset, clears all entries
//            shift_en_i    advance the register (low while the pipe is frozen)
//            push_valid_i  ID/EX instruction is a load with a non-x0 rd
//            push_rd_i     destination register of the ID/EX instruction
//            rs1_i, rs2_i  ID-stage source register indices
//            rs1_hit_o     some valid entry targets rs1_i
//            rs2_hit_o     some valid entry targets rs2_i
// Revision : 1.0 - initial release
// ============================================================================
module load_pending_sreg
   import pipe_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              shift_en_i,
   input  logic              push_valid_i,
   input  logic [REG_AW-1:0] push_rd_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   output logic              rs1_hit_o,
   output logic              rs2_hit_o
);

   pend_entry_t pend_q [DEPTH];
   pend_entry_t pend_d [DEPTH];

   // Next state: new entry enters at the head, the oldest falls off the end.
   always_comb begin
      pend_d[0].valid = push_valid_i;
      pend_d[0].rd    = push_rd_i;
      for (int k = 1; k < DEPTH; k++) begin
         pend_d[k] = pend_q[k-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            pend_q[k] <= '0;
         end
      end else if (shift_en_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            pend_q[k] <= pend_d[k];
         end
      end
   end

   always_comb begin
      rs1_hit_o = 1'b0;
      rs2_hit_o = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (pend_q[k].valid && (pend_q[k].rd == rs1_i)) rs1_hit_o = 1'b1;
         if (pend_q[k].valid && (pend_q[k].rd == rs2_i)) rs2_hit_o = 1'b1;
      end
   end

endmodule : load_pending_sreg
`default_nettype wire

// File: rtl/load_use_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : load_use_hazard_ctrl
// Purpose  : Load-use hazard detection between ID and the ID/EX register.
//            A dependent instruction behind a load receives LOAD_LAT bubbles
//            (fewer if it is further behind). A data-memory stall freezes the
//            whole pipe without inserting a bubble. Bubble cycles are counted
//            in a saturating counter.
// Ports    : clk_i        rising-edge clock
//            rst_i        asynchronous active-low reset
//            MemRead_i    ID/EX instruction is a load
//            rd_i         ID/EX destination register
//            rs1_i/rs2_i  ID-stage source registers
//            rs1_used_i/rs2_used_i  ID instruction actually reads the source
//            flush_i      ID instruction is being flushed this cycle
//            mem_stall_i  data memory busy, freeze the pipe
//            NoOp_o       insert a bubble into ID/EX
//            Stall_o      hold IF/ID
//            PCWrite_o    PC write enable
//            stall_cnt_o  saturating count of bubble cycles
// Revision : 1.0 - initial release
// ============================================================================
module load_use_hazard_ctrl #(
   parameter int REG_AW   = pipe_pkg::REG_AW,  // must match the package width
   parameter int LOAD_LAT = 1,                 // legal range 1..8
   parameter int CNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic              rs1_used_i,
   input  logic              rs2_used_i,
   input  logic              flush_i,
   input  logic              mem_stall_i,
   output logic              NoOp_o,
   output logic              Stall_o,
   output logic              PCWrite_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   import pipe_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             pend_hit1;
   logic             pend_hit2;
   logic             match1;
   logic             match2;
   logic             hazard;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // With LOAD_LAT=1 the ID/EX compare alone covers the whole window, so no
   // pending storage is built.
   generate
      if (LOAD_LAT > 1) begin : g_pending
         load_pending_sreg #(
            .DEPTH (LOAD_LAT - 1)
         ) u_pending (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .shift_en_i   (!mem_stall_i),
            .push_valid_i (MemRead_i && (rd_i != X0_IDX)),
            .push_rd_i    (rd_i),
            .rs1_i        (rs1_i),
            .rs2_i        (rs2_i),
            .rs1_hit_o    (pend_hit1),
            .rs2_hit_o    (pend_hit2)
         );
      end else begin : g_no_pending
         assign pend_hit1 = 1'b0;
         assign pend_hit2 = 1'b0;
      end
   endgenerate

   // Pending entries never hold rd=x0, but the ID/EX compare must exclude it.
   assign match1 = rs1_used_i && (rs1_i != X0_IDX) &&
                   ((MemRead_i && (rd_i == rs1_i)) || pend_hit1);
   assign match2 = rs2_used_i && (rs2_i != X0_IDX) &&
                   ((MemRead_i && (rd_i == rs2_i)) || pend_hit2);

   // A flushed ID instruction is discarded anyway, so it must not stall.
   assign hazard = (match1 || match2) && !flush_i;

   // Memory freeze dominates: hold everything, no bubble.
   always_comb begin
      Stall_o   = 1'b0;
      PCWrite_o = 1'b1;
      NoOp_o    = 1'b0;
      if (mem_stall_i) begin
         Stall_o   = 1'b1;
         PCWrite_o = 1'b0;
      end else if (hazard) begin
         Stall_o   = 1'b1;
         PCWrite_o = 1'b0;
         NoOp_o    = 1'b1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (NoOp_o && !mem_stall_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt_o = cnt_q;

endmodule : load_use_hazard_ctrl
`default_nettype wire

// File: tb/tb_load_use_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_use_hazard_ctrl
// Purpose  : Four hazard controllers (LOAD_LAT 1,2,3,4; the last with a 2-bit
//            counter) share one stimulus stream. A reference model keeps, per
//            instance, the history of registers written by loads that left
//            ID/EX in each of the last cycles, and predicts outputs. Expected
//            results are queued by the driver and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_use_hazard_ctrl;

   localparam int NI = 4;

   logic       clk;
   logic       rst_i;
   logic       MemRead_i;
   logic [4:0] rd_i;
   logic [4:0] rs1_i;
   logic [4:0] rs2_i;
   logic       rs1_used_i;
   logic       rs2_used_i;
   logic       flush_i;
   logic       mem_stall_i;

   logic [NI-1:0] noop_w;
   logic [NI-1:0] stall_w;
   logic [NI-1:0] pcw_w;
   logic [15:0]   cnt0, cnt1, cnt2;
   logic [1:0]    cnt3;
   logic [NI-1:0][15:0] act_cnt;

   assign act_cnt = {{14'd0, cnt3}, cnt2, cnt1, cnt0};

   typedef struct packed {
      logic [NI-1:0]       noop;
      logic [NI-1:0]       stall;
      logic [NI-1:0]       pcw;
      logic [NI-1:0][15:0] cnt;
   } exp_t;

   exp_t sb[$];

   int vectors = 0;
   int fails   = 0;

   // Reference model state
   int lat    [NI] = '{1, 2, 3, 4};
   int cntmax [NI] = '{65535, 65535, 65535, 3};
   int hist   [NI][8];   // hist[i][k]: rd of the load that left ID/EX k+1 cycles ago, 0 if none
   int mcnt   [NI];

   load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
      .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .rd_i(rd_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
      .flush_i(flush_i), .mem_stall_i(mem_stall_i),
      .NoOp_o(noop_w[0]), .Stall_o(stall_w[0]), .PCWrite_o(pcw_w[0]), .stall_cnt_o(cnt0));

   load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u_lat2 (
      .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .rd_i(rd_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
      .flush_i(flush_i), .mem_stall_i(mem_stall_i),
      .NoOp_o(noop_w[1]), .Stall_o(stall_w[1]), .PCWrite_o(pcw_w[1]), .stall_cnt_o(cnt1));

   load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
      .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .rd_i(rd_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
      .flush_i(flush_i), .mem_stall_i(mem_stall_i),
      .NoOp_o(noop_w[2]), .Stall_o(stall_w[2]), .PCWrite_o(pcw_w[2]), .stall_cnt_o(cnt2));

   load_use_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(2)) u_lat4 (
      .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .rd_i(rd_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
      .flush_i(flush_i), .mem_stall_i(mem_stall_i),
      .NoOp_o(noop_w[3]), .Stall_o(stall_w[3]), .PCWrite_o(pcw_w[3]), .stall_cnt_o(cnt3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Source s depends on a load still inside instance i's load-use window.
   function automatic bit depends(int i, int s, bit used, bit mr, int rd);
      bit hit;
      if (!used || s == 0) return 1'b0;
      hit = mr && (rd == s);
      for (int k = 0; k < lat[i] - 1; k++) begin
         if (hist[i][k] == s) hit = 1'b1;
      end
      return hit;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NI; i++) begin
         mcnt[i] = 0;
         for (int k = 0; k < 8; k++) hist[i][k] = 0;
      end
   endtask

   // Apply one cycle of inputs just after the rising edge, queue the
   // expected outputs for this cycle, then advance the model past the next edge.
   task automatic drive(input bit mr, input int rd, input int r1, input int r2,
                        input bit u1, input bit u2, input bit fl, input bit ms,
                        input bit rn);
      exp_t e;
      bit   haz;
      @(posedge clk);
      #1;
      MemRead_i   = mr;
      rd_i        = 5'(rd);
      rs1_i       = 5'(r1);
      rs2_i       = 5'(r2);
      rs1_used_i  = u1;
      rs2_used_i  = u2;
      flush_i     = fl;
      mem_stall_i = ms;
      rst_i       = rn;
      if (!rn) clear_model();
      e = '0;
      for (int i = 0; i < NI; i++) begin
         haz = (depends(i, r1, u1, mr, rd) || depends(i, r2, u2, mr, rd)) && !fl;
         e.stall[i] = ms || haz;
         e.pcw[i]   = !(ms || haz);
         e.noop[i]  = !ms && haz;
         e.cnt[i]   = 16'(mcnt[i]);
      end
      sb.push_back(e);
      if (rn && !ms) begin
         for (int i = 0; i < NI; i++) begin
            for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = (mr && rd != 0) ? rd : 0;
            if (e.noop[i] && mcnt[i] < cntmax[i]) mcnt[i] = mcnt[i] + 1;
         end
      end
   endtask

   // Monitor: outputs are combinational, so every cycle presents a result.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         for (int i = 0; i < NI; i++) begin
            vectors++;
            if (noop_w[i] !== e.noop[i] || stall_w[i] !== e.stall[i] ||
                pcw_w[i] !== e.pcw[i] || act_cnt[i] !== e.cnt[i]) begin
               fails++;
               $display("FAIL lat%0d t=%0t noop/stall/pcw/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                        i + 1, $time, noop_w[i], stall_w[i], pcw_w[i], act_cnt[i],
                        e.noop[i], e.stall[i], e.pcw[i], e.cnt[i]);
            end
         end
      end
   end

   initial begin
      rst_i = 1'b0; MemRead_i = 1'b0; rd_i = '0; rs1_i = '0; rs2_i = '0;
      rs1_used_i = 1'b0; rs2_used_i = 1'b0; flush_i = 1'b0; mem_stall_i = 1'b0;
      clear_model();

      // Reset state, then idle
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      // lw x5 ; add x6,x5,x1 waiting in ID behind bubbles
      drive(1, 5, 5, 1, 1, 1, 0, 0, 1);
      repeat (5) drive(0, 0, 5, 1, 1, 1, 0, 0, 1);
      // Consumer two instructions behind lw x7
      drive(1, 7, 2, 2, 1, 1, 0, 0, 1);
      drive(0, 0, 1, 2, 1, 1, 0, 0, 1);
      repeat (4) drive(0, 0, 7, 0, 1, 0, 0, 0, 1);
      // lw x0 never stalls; unused rs2 matching rd never stalls
      drive(1, 0, 0, 0, 1, 1, 0, 0, 1);
      drive(0, 0, 0, 0, 1, 1, 0, 0, 1);
      drive(1, 9, 1, 9, 1, 0, 0, 0, 1);
      repeat (4) drive(0, 0, 1, 9, 1, 0, 0, 0, 1);
      // rs1 == rs2 == rd
      drive(1, 3, 3, 3, 1, 1, 0, 0, 1);
      repeat (4) drive(0, 0, 3, 3, 1, 1, 0, 0, 1);
      // Hazard interrupted by a 4-cycle memory freeze
      drive(1, 5, 5, 0, 1, 0, 0, 0, 1);
      repeat (4) drive(0, 0, 5, 0, 1, 0, 0, 1, 1);
      repeat (4) drive(0, 0, 5, 0, 1, 0, 0, 0, 1);
      // Load with flushed consumer, then consumer of x5 one and two behind
      drive(1, 5, 5, 0, 1, 0, 1, 0, 1);
      drive(0, 0, 8, 0, 1, 0, 0, 0, 1);
      repeat (3) drive(0, 0, 5, 0, 1, 0, 0, 0, 1);
      // Asynchronous reset in the middle of a bubble sequence
      drive(1, 6, 6, 0, 1, 0, 0, 0, 1);
      drive(0, 0, 6, 0, 1, 0, 0, 0, 1);
      drive(0, 0, 6, 0, 1, 0, 0, 0, 0);
      repeat (3) drive(0, 0, 6, 0, 1, 0, 0, 0, 1);

      // Randomised traffic over a small register pool to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 1) == 1,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 63) != 0);
      end

      // Let the monitor drain the last expectation, bounded
      for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         vectors++;
         fails++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule : tb_load_use_hazard_ctrl
`default_nettype wire
